pipe_stage_fifo: RTL and testbench

Parametrised elastic pipeline buffer placed between core stages (F→D, D→X, X→M, M→W). It replaces the single-slot stage register with a configurable-depth valid/ready FIFO carrying a packed stage payload of arbitrary width. It adds a synchronous flush for branch/trap redirects and occupancy and high-water-mark outputs for performance counters. It is fully registered: no combinational path from `m_ready` to `s_ready` or from `s_valid` to `m_valid`.

---
 rtl/pipe_stage_fifo.sv | 86 ++++++++
 tb/tb_pipe_stage_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline buffer between core stages: DEPTH-entry valid/ready FIFO
// with synchronous flush, occupancy and high-water-mark outputs.
// All handshake outputs come from registered occupancy, so there is no
// combinational path from m_ready to s_ready or from s_valid to m_valid.
module pipe_stage_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    hwm
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign s_ready = (count != FULL);
    assign m_valid = (count != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Head is masked while empty so stale array contents never leak.
    assign m_data  = m_valid ? mem[rp] : '0;

    // Post-update occupancy; flush discards any same-cycle push and pop.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers, occupancy and high-water mark; reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            hwm   <= '0;
        end else begin
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) wp <= ptr_inc(wp);
                if (pop)  rp <= ptr_inc(rp);
            end
            count <= count_next;
            if (count_next > hwm) hwm <= count_next;
        end
    end

    // Payload storage is not reset; only accepted pushes write it.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wp] <= s_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench for pipe_stage_fifo: four instances of different depth
// share one clock and reset; each scenario task drives its own instance and
// checks outputs against a bench-side occupancy model and a data scoreboard.
module tb_pipe_stage_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    // DEPTH=2, WIDTH=32
    logic [31:0] s_data2, m_data2;
    logic        s_valid2, s_ready2, m_valid2, m_ready2, flush2;
    logic [1:0]  count2, hwm2;
    // DEPTH=3, WIDTH=8
    logic [7:0]  s_data3, m_data3;
    logic        s_valid3, s_ready3, m_valid3, m_ready3, flush3;
    logic [1:0]  count3, hwm3;
    // DEPTH=1, WIDTH=8
    logic [7:0]  s_data1, m_data1;
    logic        s_valid1, s_ready1, m_valid1, m_ready1, flush1;
    logic [0:0]  count1, hwm1;
    // DEPTH=4, WIDTH=8
    logic [7:0]  s_data4, m_data4;
    logic        s_valid4, s_ready4, m_valid4, m_ready4, flush4;
    logic [2:0]  count4, hwm4;

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2), .flush(flush2),
        .count(count2), .hwm(hwm2));
    pipe_stage_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .s_data(s_data3), .s_valid(s_valid3), .s_ready(s_ready3),
        .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready3), .flush(flush3),
        .count(count3), .hwm(hwm3));
    pipe_stage_fifo #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .flush(flush1),
        .count(count1), .hwm(hwm1));
    pipe_stage_fifo #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready4), .flush(flush4),
        .count(count4), .hwm(hwm4));

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (s_ready2 !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready2); end
            total++; if (m_valid2 !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid2); end
            total++; if (m_data2 !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data2); end
            total++; if (count2 !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count2); end
            total++; if (hwm2 !== 2'd0) begin bad++; $display("FAIL reset_hwm got=%0d want=0", hwm2); end
            tick();
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] q[$];
        logic [31:0] vals[3];
        logic [31:0] exp;
        int mc = 0;
        vals = '{32'h11, 32'h22, 32'h33};
        m_ready2 = 1'b0;
        s_valid2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data2 = vals[i];
            total++; if (s_ready2 !== (mc != 2)) begin bad++; $display("FAIL fill_s_ready i=%0d got=%b want=%b", i, s_ready2, (mc != 2)); end
            if (mc != 2) begin q.push_back(vals[i]); mc++; end
            tick();
        end
        s_valid2 = 1'b0;
        total++; if (count2 !== 2'd2) begin bad++; $display("FAIL fill_count got=%0d want=2", count2); end
        total++; if (s_ready2 !== 1'b0) begin bad++; $display("FAIL fill_full got=%b want=0", s_ready2); end
        m_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (m_valid2 !== (mc != 0)) begin bad++; $display("FAIL drain_m_valid i=%0d got=%b want=%b", i, m_valid2, (mc != 0)); end
            total++; if (count2 !== 2'(mc)) begin bad++; $display("FAIL drain_count i=%0d got=%0d want=%0d", i, count2, mc); end
            if (mc != 0) begin
                exp = q.pop_front();
                total++; if (m_data2 !== exp) begin bad++; $display("FAIL drain_data i=%0d got=%h want=%h", i, m_data2, exp); end
                mc--;
            end
            tick();
        end
        m_ready2 = 1'b0;
        total++; if (hwm2 !== 2'd2) begin bad++; $display("FAIL drain_hwm got=%0d want=2", hwm2); end
        total++; if (m_data2 !== 32'h0) begin bad++; $display("FAIL drain_masked got=%h want=0", m_data2); end
    endtask

    task automatic test_wrap_d3();
        logic [7:0] q[$];
        logic [7:0] exp;
        int mc = 0, sent = 0, rcvd = 0, cyc = 0, peak = 0;
        bit pu, po;
        while (rcvd < 10 && cyc < 80) begin
            s_valid3 = (sent < 10);
            s_data3  = 8'(sent);
            m_ready3 = (cyc % 2 == 0);
            pu = s_valid3 && (mc != 3);
            po = m_ready3 && (mc != 0);
            total++; if (s_ready3 !== (mc != 3)) begin bad++; $display("FAIL d3_s_ready cyc=%0d got=%b want=%b", cyc, s_ready3, (mc != 3)); end
            total++; if (m_valid3 !== (mc != 0)) begin bad++; $display("FAIL d3_m_valid cyc=%0d got=%b want=%b", cyc, m_valid3, (mc != 0)); end
            if (po) begin
                exp = q.pop_front();
                total++; if (m_data3 !== exp) begin bad++; $display("FAIL d3_data cyc=%0d got=%0d want=%0d", cyc, m_data3, exp); end
                rcvd++;
            end
            if (pu) begin q.push_back(8'(sent)); sent++; end
            mc = mc + int'(pu) - int'(po);
            if (mc > peak) peak = mc;
            tick();
            cyc++;
        end
        s_valid3 = 1'b0;
        m_ready3 = 1'b0;
        total++; if (rcvd != 10) begin bad++; $display("FAIL d3_timeout got=%0d want=10", rcvd); end
        total++; if (hwm3 !== 2'(peak)) begin bad++; $display("FAIL d3_hwm got=%0d want=%0d", hwm3, peak); end
        total++; if (m_valid3 !== 1'b0) begin bad++; $display("FAIL d3_empty got=%b want=0", m_valid3); end
    endtask

    task automatic test_single_slot();
        logic [7:0] q[$];
        logic [7:0] exp;
        int mc = 0, xfers = 0;
        bit pu, po;
        s_valid1 = 1'b1;
        m_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data1 = 8'(i + 8'h40);
            pu = (mc == 0);
            po = (mc != 0);
            total++; if (s_ready1 !== (i % 2 == 0)) begin bad++; $display("FAIL d1_s_ready i=%0d got=%b want=%b", i, s_ready1, (i % 2 == 0)); end
            if (po) begin
                exp = q.pop_front();
                total++; if (m_data1 !== exp) begin bad++; $display("FAIL d1_data i=%0d got=%h want=%h", i, m_data1, exp); end
                xfers++;
            end
            if (pu) q.push_back(s_data1);
            mc = mc + int'(pu) - int'(po);
            tick();
        end
        s_valid1 = 1'b0;
        m_ready1 = 1'b0;
        total++; if (xfers != 4) begin bad++; $display("FAIL d1_xfers got=%0d want=4", xfers); end
        total++; if (hwm1 !== 1'b1) begin bad++; $display("FAIL d1_hwm got=%0d want=1", hwm1); end
    endtask

    task automatic test_flush();
        m_ready4 = 1'b0;
        s_valid4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data4 = 8'(i + 1);
            tick();
        end
        total++; if (count4 !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d want=3", count4); end
        flush4   = 1'b1;
        s_data4  = 8'hAA;
        m_ready4 = 1'b1;
        tick();
        flush4   = 1'b0;
        s_valid4 = 1'b0;
        total++; if (count4 !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count4); end
        total++; if (s_ready4 !== 1'b1) begin bad++; $display("FAIL flush_s_ready got=%b want=1", s_ready4); end
        total++; if (hwm4 !== 3'd3) begin bad++; $display("FAIL flush_hwm got=%0d want=3", hwm4); end
        for (int i = 0; i < 3; i++) begin
            total++; if (m_valid4 !== 1'b0 || m_data4 !== 8'h00) begin bad++; $display("FAIL flush_leak i=%0d got=%b/%h want=0/00", i, m_valid4, m_data4); end
            tick();
        end
        m_ready4 = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_ready4 = 1'b0;
        s_valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data4 = 8'(8'h50 + i);
            tick();
        end
        total++; if (count4 !== 3'd4) begin bad++; $display("FAIL rst_pre_count got=%0d want=4", count4); end
        total++; if (s_ready4 !== 1'b0) begin bad++; $display("FAIL rst_pre_full got=%b want=0", s_ready4); end
        total++; if (hwm4 !== 3'd4) begin bad++; $display("FAIL rst_pre_hwm got=%0d want=4", hwm4); end
        total++; if (m_data4 !== 8'h50) begin bad++; $display("FAIL rst_pre_head got=%h want=50", m_data4); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_valid4 = 1'b0;
        total++; if (count4 !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count4); end
        total++; if (hwm4 !== 3'd0) begin bad++; $display("FAIL rst_hwm got=%0d want=0", hwm4); end
        total++; if (m_valid4 !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid4); end
        total++; if (s_ready4 !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b want=1", s_ready4); end
        total++; if (m_data4 !== 8'h00) begin bad++; $display("FAIL rst_m_data got=%h want=00", m_data4); end
    endtask

    initial begin
        rst = 1'b1;
        s_data2 = '0; s_valid2 = 1'b0; m_ready2 = 1'b0; flush2 = 1'b0;
        s_data3 = '0; s_valid3 = 1'b0; m_ready3 = 1'b0; flush3 = 1'b0;
        s_data1 = '0; s_valid1 = 1'b0; m_ready1 = 1'b0; flush1 = 1'b0;
        s_data4 = '0; s_valid4 = 1'b0; m_ready4 = 1'b0; flush4 = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap_d3();
        test_single_slot();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
